// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle for the two-port memory arbiter.
// slave is the arbiter's view; master is the view of the caches and memory.
interface mem_arbiter_if;
    logic        i_read;
    logic [5:0]  i_address;
    logic [31:0] i_readdata;
    logic        i_busywait;

    logic        d_read;
    logic        d_write;
    logic [5:0]  d_address;
    logic [31:0] d_writedata;
    logic [31:0] d_readdata;
    logic        d_busywait;

    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport slave (
        input  i_read, i_address,
        output i_readdata, i_busywait,
        input  d_read, d_write, d_address, d_writedata,
        output d_readdata, d_busywait,
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    modport master (
        output i_read, i_address,
        input  i_readdata, i_busywait,
        output d_read, d_write, d_address, d_writedata,
        input  d_readdata, d_busywait,
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache block transfers onto one main memory.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is D-over-I priority.
module mem_arbiter (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        DONE_I,
        DONE_D
    } state_t;

    state_t      state;
    logic        seen_busy;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] i_readdata;
    logic [31:0] d_readdata;

    logic        i_req;
    logic        d_req;
    logic        pick_d;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
    // On a tie the requester that was not served last wins.
    assign pick_d = d_req & (~i_req | ~last_d);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            seen_busy     <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d        <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_d) begin
                        state         <= GRANT_D;
                        // A write-back wins over a simultaneous (illegal) read.
                        mem_read      <= bus.d_read & ~bus.d_write;
                        mem_write     <= bus.d_write;
                        mem_address   <= bus.d_address;
                        mem_writedata <= bus.d_writedata;
                    end else if (i_req) begin
                        state         <= GRANT_I;
                        mem_read      <= 1'b1;
                        mem_write     <= 1'b0;
                        mem_address   <= bus.i_address;
                        mem_writedata <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (!seen_busy) begin
                        if (bus.mem_busywait) begin
                            seen_busy <= 1'b1;
                        end
                    end else if (!bus.mem_busywait) begin
                        seen_busy <= 1'b0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (state == GRANT_I) begin
                            state      <= DONE_I;
                            i_readdata <= bus.mem_readdata;
`ifdef ARB_ROUND_ROBIN_EN
                            last_d     <= 1'b0;
`endif
                        end else begin
                            state <= DONE_D;
                            if (mem_read) begin
                                d_readdata <= bus.mem_readdata;
                            end
`ifdef ARB_ROUND_ROBIN_EN
                            last_d <= 1'b1;
`endif
                        end
                    end
                end
                DONE_I, DONE_D: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.mem_address   = mem_address;
    assign bus.mem_writedata = mem_writedata;
    assign bus.i_readdata    = i_readdata;
    assign bus.d_readdata    = d_readdata;

    assign bus.i_busywait = bus.i_read & (state != DONE_I);
    assign bus.d_busywait = d_req & (state != DONE_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small busy-wait main memory model.
// Expected order for repeated ties follows ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    localparam int LAT = 5;

    logic [31:0] mem [64];
    int          cnt;
    logic        cool;

    function automatic logic [31:0] exp_mem(input logic [5:0] a);
        return (a == 6'h05) ? 32'hDEADBEEF : {8'hA5, 18'h0, a};
    endfunction

    // Memory: busy goes high one cycle after a request, stays LAT cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_busywait <= 1'b0;
            bus.mem_readdata <= '0;
            cnt              <= 0;
            cool             <= 1'b0;
            for (int i = 0; i < 64; i++) mem[i] <= exp_mem(6'(i));
        end else if (bus.mem_busywait) begin
            if (cnt == 1) begin
                bus.mem_busywait <= 1'b0;
                cool             <= 1'b1;
                if (bus.mem_read)
                    bus.mem_readdata <= mem[bus.mem_address];
                if (bus.mem_write)
                    mem[bus.mem_address] <= bus.mem_writedata;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (cool) begin
            cool <= 1'b0;
        end else if (bus.mem_read || bus.mem_write) begin
            bus.mem_busywait <= 1'b1;
            cnt              <= LAT;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          mr;
        logic        flag;
        logic        flag2;
        logic [5:0]  first;
        logic [5:0]  order [3];
        logic [5:0]  exp_order [3];
        logic        tmo;

        reset           = 1'b1;
        bus.i_read      = 1'b0;
        bus.i_address   = '0;
        bus.d_read      = 1'b0;
        bus.d_write     = 1'b0;
        bus.d_address   = '0;
        bus.d_writedata = '0;

        #2;
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr", bus.mem_address, 0);
        chk("rst_mem_wdata", bus.mem_writedata, 0);
        chk("rst_i_rdata", bus.i_readdata, 0);
        chk("rst_d_rdata", bus.d_readdata, 0);
        chk("rst_i_bw", bus.i_busywait, 0);
        chk("rst_d_bw", bus.d_busywait, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single I read of address 5
        bus.i_read    = 1'b1;
        bus.i_address = 6'h05;
        n = 0; mr = 0; flag = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (bus.mem_read) mr++;
            if (bus.d_busywait) flag = 1'b1;
        end while (bus.i_busywait && n < 100);
        chk("i_latency", n, LAT + 3);
        chk("i_memread_cycles", mr, LAT + 2);
        chk("i_rdata", bus.i_readdata, 32'hDEADBEEF);
        chk("i_done_memread", bus.mem_read, 0);
        chk("i_d_bw_quiet", flag, 0);
        @(negedge clk);
        chk("i_bw_back_high", bus.i_busywait, 1);
        bus.i_read = 1'b0;
        @(negedge clk);
        chk("i_idle_memread", bus.mem_read, 0);

        // D write-back
        bus.d_write     = 1'b1;
        bus.d_address   = 6'h3F;
        bus.d_writedata = 32'h12345678;
        n = 0; flag = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (bus.d_busywait &&
                !(bus.mem_write && !bus.mem_read &&
                  bus.mem_address == 6'h3F &&
                  bus.mem_writedata == 32'h12345678))
                flag = 1'b0;
        end while (bus.d_busywait && n < 100);
        chk("d_wr_latency", n, LAT + 3);
        chk("d_wr_forward", flag, 1);
        chk("d_wr_rdata_kept", bus.d_readdata, 0);
        chk("d_wr_mem", mem[6'h3F], 32'h12345678);
        bus.d_write = 1'b0;
        @(negedge clk);

        // Illegal read+write: write forwarded
        bus.d_read      = 1'b1;
        bus.d_write     = 1'b1;
        bus.d_address   = 6'h30;
        bus.d_writedata = 32'hCAFEF00D;
        @(negedge clk);
        chk("ill_mem_write", bus.mem_write, 1);
        chk("ill_mem_read", bus.mem_read, 0);
        n = 0;
        while (bus.d_busywait && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ill_done", bus.d_busywait, 0);
        chk("ill_mem", mem[6'h30], 32'hCAFEF00D);
        chk("ill_rdata_kept", bus.d_readdata, 0);
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        @(negedge clk);

        reset = 1'b1;
        #1;
        reset = 1'b0;
        @(negedge clk);

        // Simultaneous I and D reads
        bus.i_read    = 1'b1;
        bus.i_address = 6'h0A;
        bus.d_read    = 1'b1;
        bus.d_address = 6'h0B;
        n = 0; flag = 1'b1; first = '0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) first = bus.mem_address;
            if (!bus.i_busywait) flag = 1'b0;
        end while (bus.d_busywait && n < 100);
        chk("tie_first_addr", first, 6'h0B);
        chk("tie_i_bw_held", flag, 1);
        chk("tie_d_rdata", bus.d_readdata, exp_mem(6'h0B));
        bus.d_read = 1'b0;
        @(negedge clk);
        chk("tie_idle_i_bw", bus.i_busywait, 1);
        chk("tie_idle_memread", bus.mem_read, 0);
        @(negedge clk);
        chk("tie_i_grant", bus.mem_read, 1);
        chk("tie_i_addr", bus.mem_address, 6'h0A);
        n = 0;
        while (bus.i_busywait && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tie_i_rdata", bus.i_readdata, exp_mem(6'h0A));
        bus.i_read = 1'b0;
        @(negedge clk);

        // Three back-to-back ties
        bus.i_read    = 1'b1;
        bus.i_address = 6'h10;
        bus.d_read    = 1'b1;
        bus.d_address = 6'h20;
        tmo = 1'b0;
        for (int g = 0; g < 3; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.mem_read && n < 100);
            if (n >= 100) tmo = 1'b1;
            order[g] = bus.mem_address;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.mem_read && n < 100);
            if (n >= 100) tmo = 1'b1;
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        chk("rr_no_timeout", tmo, 0);
`ifdef ARB_ROUND_ROBIN_EN
        exp_order[0] = 6'h20;
        exp_order[1] = 6'h10;
        exp_order[2] = 6'h20;
`else
        exp_order[0] = 6'h20;
        exp_order[1] = 6'h20;
        exp_order[2] = 6'h20;
`endif
        chk("order0", order[0], exp_order[0]);
        chk("order1", order[1], exp_order[1]);
        chk("order2", order[2], exp_order[2]);
        @(negedge clk);
        @(negedge clk);

        // Reset in the 3rd busy cycle of a D read
        bus.d_read    = 1'b1;
        bus.d_address = 6'h07;
        @(negedge clk);
        chk("rst_mid_grant", bus.mem_read, 1);
        repeat (3) @(negedge clk);
        chk("rst_mid_busy", bus.mem_busywait, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_memread", bus.mem_read, 0);
        chk("rst_mid_d_rdata", bus.d_readdata, 0);
        chk("rst_mid_d_bw", bus.d_busywait, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_regrant", bus.mem_read, 1);
        chk("rst_regrant_addr", bus.mem_address, 6'h07);
        n = 0;
        while (bus.d_busywait && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_regrant_rdata", bus.d_readdata, exp_mem(6'h07));
        bus.d_read = 1'b0;
        @(negedge clk);

        // Address change during grant is ignored
        bus.d_read    = 1'b1;
        bus.d_address = 6'h01;
        @(negedge clk);
        bus.d_address = 6'h02;
        n = 0; flag = 1'b1; flag2 = bus.mem_read;
        do begin
            @(negedge clk);
            n++;
            if (bus.mem_address != 6'h01) flag = 1'b0;
        end while (bus.d_busywait && n < 100);
        chk("hold_granted", flag2, 1);
        chk("hold_addr", flag, 1);
        chk("hold_done_addr", bus.mem_address, 6'h01);
        chk("hold_rdata", bus.d_readdata, exp_mem(6'h01));
        bus.d_read = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
